// File: rtl/ble_cmd_tx.sv
// BLE-side command UART transmitter: 4-deep byte FIFO feeding an 8N1, LSB-first serialiser.
// Define BLE_KEEPALIVE_EN to resend 'G' after KA_PERIOD idle cycles once a 'G' was last sent.
module ble_cmd_tx #(
   parameter int unsigned BAUD_DIV   = 2604,
   parameter int unsigned FIFO_DEPTH = 4
`ifdef BLE_KEEPALIVE_EN
   ,
   parameter logic [23:0] KA_PERIOD  = 24'd5_000_000
`endif
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    cmd,
   input  logic                          cmd_vld,
   output logic                          cmd_rdy,
   output logic                          TX,
   output logic                          tx_busy,
   output logic                          tx_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

   localparam int          PW        = $clog2(FIFO_DEPTH);
   localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
   localparam logic [PW:0] DEPTH     = (PW + 1)'(FIFO_DEPTH);
   localparam logic [7:0]  CMD_G     = 8'h47;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [1:0]    state;
   logic [11:0]   baud_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    sh;

   logic       push, pop, bit_end, ka_fire, start_frame;
   logic [7:0] next_byte;

   assign cmd_rdy     = (fifo_cnt != DEPTH);
   assign push        = cmd_vld & cmd_rdy;
   assign pop         = (state == IDLE) && (fifo_cnt != '0);
   assign start_frame = pop | ka_fire;
   assign next_byte   = pop ? mem[rd_ptr] : CMD_G;
   assign bit_end     = (baud_cnt == BAUD_LAST);

   // NOTE: storage carries no reset; only the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= cmd;
   end

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         sh       <= '0;
      end else begin
         case (state)
            IDLE: begin
               baud_cnt <= '0;
               if (start_frame) begin
                  sh    <= next_byte;
                  state <= START;
               end
            end
            START: begin
               baud_cnt <= bit_end ? 12'd0 : baud_cnt + 12'd1;
               if (bit_end) begin
                  bit_cnt <= '0;
                  state   <= DATA;
               end
            end
            DATA: begin
               baud_cnt <= bit_end ? 12'd0 : baud_cnt + 12'd1;
               if (bit_end) begin
                  sh      <= {1'b0, sh[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7)
                     state <= STOP;
               end
            end
            default: begin
               baud_cnt <= bit_end ? 12'd0 : baud_cnt + 12'd1;
               if (bit_end)
                  state <= IDLE;
            end
         endcase
      end
   end

`ifdef BLE_KEEPALIVE_EN
   logic [23:0] ka_cnt;
   logic        ka_armed;
   logic        ka_idle;

   assign ka_idle = (state == IDLE) && (fifo_cnt == '0);
   assign ka_fire = ka_idle && ka_armed && (ka_cnt == KA_PERIOD - 24'd1);

   always_ff @(posedge clk) begin
      if (rst) begin
         ka_cnt   <= '0;
         ka_armed <= 1'b0;
      end else begin
         // Armed state tracks the most recently started frame's byte.
         if (start_frame)
            ka_armed <= (next_byte == CMD_G);
         if (push || start_frame)
            ka_cnt <= '0;
         else if (ka_idle)
            ka_cnt <= (ka_cnt == KA_PERIOD - 24'd1) ? 24'd0 : ka_cnt + 24'd1;
      end
   end
`else
   assign ka_fire = 1'b0;
`endif

   // NOTE: default assignment first keeps this combinational block latch-free.
   always_comb begin
      TX = 1'b1;
      case (state)
         START:   TX = 1'b0;
         DATA:    TX = sh[0];
         default: TX = 1'b1;
      endcase
   end

   assign tx_busy = (state != IDLE);
   assign tx_done = (state == STOP) && bit_end;

endmodule

// File: tb/tb_ble_cmd_tx.sv
// Directed bench for ble_cmd_tx with a short bit period; keepalive steps run when
// BLE_KEEPALIVE_EN is defined for both bench and design.
module tb_ble_cmd_tx;

   localparam int BD    = 16;
   localparam int FRAME = 10 * BD;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] cmd = 8'h00;
   logic       cmd_vld = 1'b0;
   logic       cmd_rdy, TX, tx_busy, tx_done;
   logic [2:0] fifo_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ble_cmd_tx #(
      .BAUD_DIV   (BD),
      .FIFO_DEPTH (4)
`ifdef BLE_KEEPALIVE_EN
      ,
      .KA_PERIOD  (24'd1000)
`endif
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cmd      (cmd),
      .cmd_vld  (cmd_vld),
      .cmd_rdy  (cmd_rdy),
      .TX       (TX),
      .tx_busy  (tx_busy),
      .tx_done  (tx_done),
      .fifo_cnt (fifo_cnt)
   );

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push1(input logic [7:0] b);
      cmd     = b;
      cmd_vld = 1'b1;
      tick();
      cmd_vld = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (tx_done !== 1'b1 && n < 400) begin
         tick();
         n++;
      end
      check(tag, 32'(n < 400), 32'd1);
   endtask

   // Returns in the middle of the stop bit.
   task automatic get_byte(input string tag, output logic [7:0] b);
      int n = 0;
      b = 8'h00;
      while (TX !== 1'b0 && n < 3000) begin
         tick();
         n++;
      end
      check({tag, "_start"}, 32'(TX), 32'd0);
      tick(BD / 2);
      for (int i = 0; i < 8; i++) begin
         tick(BD);
         b[i] = TX;
      end
      tick(BD);
      check({tag, "_stop"}, 32'(TX), 32'd1);
   endtask

   initial begin
      logic [9:0] exp10;
      logic [7:0] q2 [4];
      logic [7:0] q3 [3];
      logic [7:0] rx;
      int dc, dat, lows, n;

      // Reset state
      tick(3);
      check("rst_tx", 32'(TX), 32'd1);
      check("rst_busy", 32'(tx_busy), 32'd0);
      check("rst_done", 32'(tx_done), 32'd0);
      check("rst_cnt", 32'(fifo_cnt), 32'd0);
      check("rst_rdy", 32'(cmd_rdy), 32'd1);
      rst = 1'b0;
      tick();

      // Single 'G': first-word latency, line pattern, tx_done timing
      push1(8'h47);
      check("lat_cnt1", 32'(fifo_cnt), 32'd1);
      check("lat_tx_idle", 32'(TX), 32'd1);
      tick();
      check("lat_tx_fall", 32'(TX), 32'd0);
      check("lat_busy", 32'(tx_busy), 32'd1);
      check("lat_cnt0", 32'(fifo_cnt), 32'd0);
      exp10 = 10'b1_0100_0111_0;
      dc  = 0;
      dat = -1;
      for (int c = 0; c < FRAME; c++) begin
         if (c % BD == BD / 2)
            check($sformatf("g_bit%0d", c / BD), 32'(TX), 32'(exp10[c / BD]));
         if (tx_done === 1'b1) begin
            dc++;
            dat = c;
         end
         tick();
      end
      // tx_done occupies the final cycle of the 10-bit frame
      check("g_done_cycle", 32'(dat), 32'(FRAME - 1));
      check("g_done_count", 32'(dc), 32'd1);
      check("g_end_tx", 32'(TX), 32'd1);
      check("g_end_busy", 32'(tx_busy), 32'd0);

      // Fill the FIFO while busy; 5th push dropped
      push1(8'hA5);
      tick();
      q2 = '{8'h47, 8'h53, 8'h47, 8'h53};
      for (int i = 0; i < 4; i++) begin
         cmd     = q2[i];
         cmd_vld = 1'b1;
         tick();
      end
      check("full_cnt", 32'(fifo_cnt), 32'd4);
      check("full_rdy", 32'(cmd_rdy), 32'd0);
      cmd = 8'h47;
      tick();
      cmd_vld = 1'b0;
      check("drop_cnt", 32'(fifo_cnt), 32'd4);
      wait_done("a5_done");
      for (int k = 0; k < 4; k++) begin
         get_byte($sformatf("q%0d", k), rx);
         check($sformatf("q%0d_byte", k), 32'(rx), 32'(q2[k]));
         check($sformatf("q%0d_cnt", k), 32'(fifo_cnt), 32'(3 - k));
      end

      // Simultaneous push/pop and pointer wrap
      wait_done("t3_pre");
      tick(2);
      cmd = 8'hB1; cmd_vld = 1'b1; tick();
      cmd = 8'hC2; tick();
      check("pp_cnt1", 32'(fifo_cnt), 32'd1);
      cmd = 8'hD3; tick();
      cmd_vld = 1'b0;
      check("pp_cnt2_pre", 32'(fifo_cnt), 32'd2);
      wait_done("b1_done");
      tick();
      cmd = 8'hE4; cmd_vld = 1'b1; tick();
      cmd_vld = 1'b0;
      check("pp_cnt2", 32'(fifo_cnt), 32'd2);
      check("pp_busy", 32'(tx_busy), 32'd1);
      q3 = '{8'hC2, 8'hD3, 8'hE4};
      for (int k = 0; k < 3; k++) begin
         get_byte($sformatf("w%0d", k), rx);
         check($sformatf("w%0d_byte", k), 32'(rx), 32'(q3[k]));
      end

      // Reset during DATA bit 4 with a byte still queued
      wait_done("t4_pre");
      tick(2);
      push1(8'h00);
      cmd = 8'hFF; cmd_vld = 1'b1; tick();
      cmd_vld = 1'b0;
      tick(5 * BD + 3);
      check("mid_tx", 32'(TX), 32'd0);
      check("mid_busy", 32'(tx_busy), 32'd1);
      check("mid_cnt", 32'(fifo_cnt), 32'd1);
      rst = 1'b1;
      tick();
      check("abort_tx", 32'(TX), 32'd1);
      check("abort_busy", 32'(tx_busy), 32'd0);
      check("abort_cnt", 32'(fifo_cnt), 32'd0);
      check("abort_rdy", 32'(cmd_rdy), 32'd1);
      check("abort_done", 32'(tx_done), 32'd0);
      rst = 1'b0;
      dc   = 0;
      lows = 0;
      for (int c = 0; c < 2 * FRAME; c++) begin
         if (tx_done === 1'b1) dc++;
         if (TX !== 1'b1) lows++;
         tick();
      end
      check("abort_no_done", 32'(dc), 32'd0);
      check("abort_quiet", 32'(lows), 32'd0);
      push1(8'h53);
      get_byte("s_after", rx);
      check("s_after_byte", 32'(rx), 32'h53);

`ifdef BLE_KEEPALIVE_EN
      // Keepalive: 'G' re-sent 1000 idle cycles after tx_done, stopped by 'S'
      wait_done("ka_pre");
      tick(2);
      push1(8'h47);
      get_byte("ka_g", rx);
      check("ka_g_byte", 32'(rx), 32'h47);
      wait_done("ka_done");
      n = 0;
      while (TX !== 1'b0 && n < 3000) begin
         tick();
         n++;
      end
      // one tick to leave the tx_done cycle, then 1000 idle cycles
      check("ka_gap", 32'(n), 32'd1001);
      get_byte("ka_inj", rx);
      check("ka_inj_byte", 32'(rx), 32'h47);
      push1(8'h53);
      get_byte("ka_s", rx);
      check("ka_s_byte", 32'(rx), 32'h53);
      wait_done("ka_s_done");
      lows = 0;
      for (int c = 0; c < 3000; c++) begin
         if (TX !== 1'b1) lows++;
         tick();
      end
      check("ka_disarmed", 32'(lows), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
